// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake and data-memory port of the load/store unit.
interface load_store_unit_if #(parameter int REG_BITS = 32);
    logic                req;
    logic                we;
    logic [2:0]          funct3;
    logic [REG_BITS-1:0] addr;
    logic [REG_BITS-1:0] wdata;
    logic                ready;
    logic                valid;
    logic                err;
    logic [REG_BITS-1:0] rdata;
    logic [REG_BITS-1:0] mem_a;
    logic [REG_BITS-1:0] mem_wd;
    logic                mem_we;
    logic [REG_BITS-1:0] mem_rd;
    modport master (
        output req, we, funct3, addr, wdata, mem_rd,
        input  ready, valid, err, rdata, mem_a, mem_wd, mem_we
    );
    modport slave (
        input  req, we, funct3, addr, wdata, mem_rd,
        output ready, valid, err, rdata, mem_a, mem_wd, mem_we
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer for a word-wide memory without byte enables.
// Define LSU_SUBWORD_STORE_EN to build SB/SH as read-modify-write; otherwise they are rejected.
module load_store_unit (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);
    localparam int REG_BITS = 32;
`ifdef LSU_SUBWORD_STORE_EN
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
`endif
    state_t              state_q, state_d;
    logic                we_q, err_q, illegal, is_sw;
    logic [2:0]          f3_q;
    logic [1:0]          off_q;
    logic [7:0]          lane_b;
    logic [15:0]         lane_h;
    logic [REG_BITS-1:0] load_val, rdata_q, mem_a_q, mem_wd_q;
    assign is_sw    = we_q && f3_q[1:0] == 2'b10;
    assign lane_b   = bus.mem_rd[{off_q, 3'b000} +: 8];
    assign lane_h   = bus.mem_rd[{off_q[1], 4'b0000} +: 16];
    assign load_val = f3_q[1] ? bus.mem_rd
                    : f3_q[0] ? {{16{lane_h[15] & ~f3_q[2]}}, lane_h}
                    : {{24{lane_b[7] & ~f3_q[2]}}, lane_b};
    assign bus.rdata  = rdata_q;
    assign bus.mem_a  = mem_a_q;
    assign bus.mem_wd = mem_wd_q;
    always_comb begin
        illegal = bus.funct3 == 3'b011 || bus.funct3[2:1] == 2'b11
               || (bus.we && bus.funct3[2])
               || (bus.funct3[1:0] == 2'b01 && bus.addr[0])
               || (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00);
`ifndef LSU_SUBWORD_STORE_EN
        illegal = illegal || (bus.we && bus.funct3[1:0] != 2'b10);
`endif
    end
`ifdef LSU_SUBWORD_STORE_EN
    logic [15:0]         wdata_q;
    logic [REG_BITS-1:0] merged;
    // Only the addressed lane is replaced; the rest of the read word passes through.
    always_comb begin
        merged = bus.mem_rd;
        if (f3_q[0]) merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
        else merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end
`endif
    always_comb begin
        state_d   = state_q;
        bus.ready = state_q == IDLE;
        bus.valid = state_q == DONE;
        bus.err   = state_q == DONE && err_q;
        bus.mem_we = state_q == ACCESS && is_sw;
        if (state_q == IDLE && bus.req) state_d = illegal ? DONE : ACCESS;
`ifdef LSU_SUBWORD_STORE_EN
        if (state_q == ACCESS) state_d = (we_q && !is_sw) ? WRITE : DONE;
        if (state_q == WRITE) begin
            state_d    = DONE;
            bus.mem_we = 1'b1;
        end
`else
        if (state_q == ACCESS) state_d = DONE;
`endif
        if (state_q == DONE) state_d = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            f3_q     <= '0;
            off_q    <= '0;
            rdata_q  <= '0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
`ifdef LSU_SUBWORD_STORE_EN
            wdata_q  <= '0;
`endif
        end else begin
            if (state_q == IDLE && bus.req) begin
                we_q  <= bus.we;
                err_q <= illegal;
                f3_q  <= bus.funct3;
                off_q <= bus.addr[1:0];
                // Rejected requests leave the memory port untouched.
                if (!illegal) mem_a_q <= {2'b00, bus.addr[REG_BITS-1:2]};
                if (!illegal && bus.we && bus.funct3[1:0] == 2'b10) mem_wd_q <= bus.wdata;
`ifdef LSU_SUBWORD_STORE_EN
                wdata_q <= bus.wdata[15:0];
`endif
            end
            if (state_q == ACCESS && !we_q) rdata_q <= load_val;
`ifdef LSU_SUBWORD_STORE_EN
            if (state_q == ACCESS && we_q && !is_sw) mem_wd_q <= merged;
`endif
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a behavioural model.
module tb_load_store_unit;
`ifdef LSU_SUBWORD_STORE_EN
    localparam bit SUBW = 1'b1;
`else
    localparam bit SUBW = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    int          checks = 0, failures = 0;
    int          rem = 0, accepts = 0;
    bit          p_legal = 1'b0, p_we = 1'b0;
    logic [3:0]  p_idx = '0;
    logic [31:0] p_new = '0, p_load = '0, exp_rdata = '0, exp_mem_a = '0;

    load_store_unit_if bus ();
    load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    assign bus.mem_rd = mem[bus.mem_a[3:0]];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_a[3:0]] <= bus.mem_wd;
        else if (pl_en) mem[pl_idx] <= pl_val;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] f);
        return f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
    endfunction

    function automatic bit legal(input logic w, input logic [2:0] f, input logic [31:0] a);
        if (f == 3'b011 || f >= 3'b110) return 1'b0;
        if (w && (f[2] || (size_of(f) < 4 && !SUBW))) return 1'b0;
        return (a % 32'(size_of(f))) == 0;
    endfunction

    function automatic logic [31:0] load_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * a[1:0]);
        if (size_of(f) == 1) v = (f[2] || !v[7]) ? (v & 32'hFF) : (v | 32'hFFFFFF00);
        if (size_of(f) == 2) v = (f[2] || !v[15]) ? (v & 32'hFFFF) : (v | 32'hFFFF0000);
        return v;
    endfunction

    function automatic logic [31:0] store_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                                             input logic [31:0] old);
        logic [31:0] mask;
        int sh;
        sh = 8 * a[1:0];
        mask = size_of(f) == 4 ? 32'hFFFFFFFF : size_of(f) == 2 ? (32'hFFFF << sh) : (32'hFF << sh);
        return (old & ~mask) | ((d << sh) & mask);
    endfunction

    // Reference: rem counts the non-ready cycles left; effects land on the edge leaving rem==2.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem       <= 0;
            exp_rdata <= '0;
            exp_mem_a <= '0;
        end else begin
            if (pl_en) ref_mem[pl_idx] <= pl_val;
            if (rem > 0) begin
                if (rem == 2 && p_legal && p_we) ref_mem[p_idx] <= p_new;
                if (rem == 2 && p_legal && !p_we) exp_rdata <= p_load;
                rem <= rem - 1;
            end else if (bus.req) begin
                accepts <= accepts + 1;
                p_we    <= bus.we;
                p_legal <= legal(bus.we, bus.funct3, bus.addr);
                p_idx   <= bus.addr[5:2];
                p_load  <= load_of(bus.funct3, bus.addr, ref_mem[bus.addr[5:2]]);
                p_new   <= store_of(bus.funct3, bus.addr, bus.wdata, ref_mem[bus.addr[5:2]]);
                if (legal(bus.we, bus.funct3, bus.addr)) exp_mem_a <= {2'b00, bus.addr[31:2]};
                rem <= !legal(bus.we, bus.funct3, bus.addr) ? 1
                     : (bus.we && size_of(bus.funct3) < 4) ? 3 : 2;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", 32'(bus.ready), 32'(rem == 0));
        chk("valid", 32'(bus.valid), 32'(rem == 1));
        chk("err", 32'(bus.err), 32'(rem == 1 && !p_legal));
        chk("mem_we", 32'(bus.mem_we), 32'(rem == 2 && p_legal && p_we));
        chk("rdata", bus.rdata, exp_rdata);
        chk("mem_a", bus.mem_a, exp_mem_a);
        if (rem == 2 && p_legal && p_we) chk("mem_wd", bus.mem_wd, p_new);
        if (rem == 1 && p_legal && p_we) chk("mem_word", mem[p_idx], ref_mem[p_idx]);
    end

    task automatic preload(input int i, input logic [31:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = 4'(i); pl_val = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one request from idle, scrambles the inputs after acceptance and measures latency.
    task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic e);
        lat = 0;
        e = 1'b0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.funct3 = f; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0; bus.we = 1'($urandom); bus.funct3 = 3'($urandom);
        bus.addr = $urandom; bus.wdata = $urandom;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.valid) begin
                lat = k;
                e = bus.err;
            end
        end
        @(negedge clk);
    endtask

    initial begin : stim
        int lat;
        logic e;
        int a0;
        int pick;
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = '0; bus.addr = '0; bus.wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_mem_a", bus.mem_a, 32'd0);
        chk("rst_mem_wd", bus.mem_wd, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        preload(5, 32'h8899AABB);
        preload(4, 32'h11223344);

        issue(1'b0, 3'b000, 32'h15, 32'h0, lat, e);
        chk("lb_lat", 32'(lat), 32'd2);
        chk("lb", bus.rdata, 32'hFFFFFFAA);
        issue(1'b0, 3'b100, 32'h15, 32'h0, lat, e);
        chk("lbu", bus.rdata, 32'h000000AA);
        issue(1'b0, 3'b001, 32'h16, 32'h0, lat, e);
        chk("lh_lat", 32'(lat), 32'd2);
        chk("lh", bus.rdata, 32'hFFFF8899);
        issue(1'b0, 3'b101, 32'h14, 32'h0, lat, e);
        chk("lhu", bus.rdata, 32'h0000AABB);

        issue(1'b0, 3'b001, 32'h13, 32'h0, lat, e);
        chk("lh_mis_lat", 32'(lat), 32'd1);
        chk("lh_mis_err", 32'(e), 32'd1);
        issue(1'b0, 3'b010, 32'h16, 32'h0, lat, e);
        chk("lw_mis_lat", 32'(lat), 32'd1);
        chk("lw_mis_err", 32'(e), 32'd1);
        issue(1'b0, 3'b011, 32'h14, 32'h0, lat, e);
        chk("f3_011_err", 32'(e), 32'd1);
        issue(1'b1, 3'b100, 32'h14, 32'hFFFFFFFF, lat, e);
        chk("sb100_lat", 32'(lat), 32'd1);
        chk("sb100_err", 32'(e), 32'd1);
        chk("rdata_kept", bus.rdata, 32'h0000AABB);
        chk("word5_kept", mem[5], 32'hDEADBEEF ^ 32'h56341454);

        issue(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, lat, e);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_word", mem[5], 32'hDEADBEEF);
        issue(1'b1, 3'b000, 32'h16, 32'h12345677, lat, e);
        chk("sb_lat", 32'(lat), SUBW ? 32'd3 : 32'd1);
        chk("sb_err", 32'(e), SUBW ? 32'd0 : 32'd1);
        chk("sb_word", mem[5], SUBW ? 32'hDE77BEEF : 32'hDEADBEEF);
        issue(1'b1, 3'b001, 32'h12, 32'h0000CAFE, lat, e);
        chk("sh_err", 32'(e), SUBW ? 32'd0 : 32'd1);
        chk("sh_word", mem[4], SUBW ? 32'hCAFE3344 : 32'h11223344);

        // Reset while the write enable is up: no write may land.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = SUBW ? 3'b000 : 3'b010;
        bus.addr = 32'h10; bus.wdata = 32'h55555555;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        if (SUBW) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_word", mem[4], SUBW ? 32'hCAFE3344 : 32'h11223344);
        chk("rst_mid_ready", 32'(bus.ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Held request: only idle edges accept, one load per three cycles.
        a0 = accepts;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            pick = $urandom_range(0, 4);
            bus.req = 1'b1; bus.we = 1'b0;
            bus.funct3 = 3'(pick < 3 ? pick : pick + 1);
            bus.addr = {26'b0, 4'($urandom), 2'b00};
        end
        @(negedge clk);
        bus.req = 1'b0;
        chk("held_accepts", 32'(accepts - a0), 32'd10);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.req = $urandom_range(0, 3) != 0;
            bus.we = 1'($urandom);
            bus.funct3 = 3'($urandom);
            bus.addr = 32'($urandom_range(0, 63));
            bus.wdata = $urandom;
        end
        @(negedge clk);
        bus.req = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "timeout");
    end
endmodule
